unified_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the core's instruction-fetch port and data (load/store) port.

---
 rtl/unified_mem_arbiter_pkg.sv | 24 ++
 rtl/arb_rd_tag_pipe.sv | 37 +++
 rtl/unified_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: read-return owner tags,
// arbitration priority states and the supported read-latency range.
package unified_mem_arbiter_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    DPRI = 1'b0,
    FPRI = 1'b1
  } arb_state_e;

  localparam int RD_LAT_MAX = 4;

  // Out-of-range latencies are pulled into 1..RD_LAT_MAX so the tag pipe always has a stage.
  function automatic int clamp_lat(input int lat);
    if (lat < 1) return 1;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// Read-return tag pipe: a DEPTH-stage {valid, owner} shift register that
// routes memory read data back to whichever port issued the read.
module arb_rd_tag_pipe
  import unified_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_valid,
  input  owner_e push_owner,
  output logic   out_valid,
  output owner_e out_owner
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] owner_q;

  // Clearing on reset drops any reads still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q[0] <= push_valid;
      owner_q[0] <= push_owner;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_owner = owner_e'(owner_q[DEPTH-1]);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict perf counters.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stallreq_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_gnt_o,
  output logic [31:0]         perf_d_gnt_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  localparam int LAT   = clamp_lat(RD_LAT);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             req_if, req_d;
  logic             gnt_if, gnt_d;
  logic             push_valid;
  owner_e           push_owner;
  logic             tag_valid;
  owner_e           tag_owner;

  // Requests are masked while reset is held so every output reads 0.
  assign req_if = if_req_i & rst;
  assign req_d  = d_req_i & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DPRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Data normally wins a conflict; after STARVE_MAX such wins fetch is forced through once.
  always_comb begin
    gnt_if   = 1'b0;
    gnt_d    = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    if (req_if && req_d) begin
      if (state_q == FPRI) begin
        gnt_if = 1'b1;
      end else begin
        gnt_d    = 1'b1;
        starve_d = starve_q + 1'b1;
        if (starve_d == CNT_W'(STARVE_MAX)) state_d = FPRI;
      end
    end else if (req_if) begin
      gnt_if = 1'b1;
    end else if (req_d) begin
      gnt_d = 1'b1;
    end
    if (gnt_if) begin
      starve_d = '0;
      state_d  = DPRI;
    end
    if (!req_if) starve_d = '0;
  end

  assign if_gnt_o   = gnt_if;
  assign d_gnt_o    = gnt_d;
  assign stallreq_o = (req_if & ~gnt_if) | (req_d & ~gnt_d);

  // A store with no byte enables still occupies the port but writes nothing.
  always_comb begin
    mem_ce_o    = gnt_if | gnt_d;
    mem_we_o    = gnt_d & d_we_i & (|d_sel_i);
    mem_sel_o   = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_if) begin
      mem_sel_o  = '1;
      mem_addr_o = if_addr_i;
    end else if (gnt_d) begin
      mem_addr_o = d_addr_i;
      mem_sel_o  = d_we_i ? d_sel_i : '1;
      if (d_we_i) mem_wdata_o = d_wdata_i;
    end
  end

  assign push_valid = gnt_if | (gnt_d & ~d_we_i);
  assign push_owner = gnt_d ? OWN_D : OWN_IF;

  arb_rd_tag_pipe #(
    .DEPTH(LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_valid),
    .push_owner(push_owner),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  assign if_rvalid_o = tag_valid & (tag_owner == OWN_IF);
  assign d_rvalid_o  = tag_valid & (tag_owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_EN
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_gnt_o   <= '0;
      perf_d_gnt_o    <= '0;
      perf_conflict_o <= '0;
    end else begin
      if (gnt_if && (perf_if_gnt_o != '1)) perf_if_gnt_o <= perf_if_gnt_o + 32'd1;
      if (gnt_d && (perf_d_gnt_o != '1)) perf_d_gnt_o <= perf_d_gnt_o + 32'd1;
      if (req_if && req_d && (perf_conflict_o != '1)) perf_conflict_o <= perf_conflict_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (RD_LAT 1 and 3) share directed
// stimulus; a scoreboard model plus hand-computed literals check both.
module tb_unified_mem_arbiter;

  localparam int STARVE = 4;
  localparam int LAT0   = 1;
  localparam int LAT1   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;

  logic [1:0]        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_ce, mem_we, stallreq;
  logic [1:0][31:0]  if_rdata, d_rdata, mem_wdata;
  logic [1:0][3:0]   mem_sel;
  logic [1:0][11:0]  mem_addr;
`ifdef MEM_ARB_PERF_EN
  logic [1:0][31:0]  perf_if, perf_d, perf_cf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return 32'hC0DE0000 | {20'h0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Each instance gets its own RAM model with write-first ordering and its own read latency.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    logic [31:0]   ram [0:4095];
    logic [4095:0] written = '0;
    logic [31:0]   rd_pipe [LAT];

    unified_mem_arbiter #(
      .ADDR_W(12), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(STARVE)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]),
      .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_gnt_o(d_gnt[g]), .d_rvalid_o(d_rvalid[g]),
      .d_rdata_o(d_rdata[g]), .mem_ce_o(mem_ce[g]), .mem_we_o(mem_we[g]),
      .mem_sel_o(mem_sel[g]), .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(rd_pipe[LAT-1]), .stallreq_o(stallreq[g])
`ifdef MEM_ARB_PERF_EN
      , .perf_if_gnt_o(perf_if[g]), .perf_d_gnt_o(perf_d[g]), .perf_conflict_o(perf_cf[g])
`endif
    );

    always @(posedge clk) begin
      if (mem_ce[g] && mem_we[g]) begin
        ram[mem_addr[g]] <= merge(written[mem_addr[g]] ? ram[mem_addr[g]] : init_word(mem_addr[g]),
                                  mem_wdata[g], mem_sel[g]);
        written[mem_addr[g]] <= 1'b1;
      end
      rd_pipe[0] <= (mem_ce[g] && !mem_we[g]) ?
                    (written[mem_addr[g]] ? ram[mem_addr[g]] : init_word(mem_addr[g])) : 32'h0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  typedef struct {
    int          due;
    int          inst;
    logic        owner;
    logic [31:0] data;
  } rd_t;

  rd_t         pend[$];
  logic [31:0] gold [int];
  int          cyc    = 0;
  int          streak = 0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] e_pif = 0, e_pd = 0, e_pcf = 0;
`endif

  function automatic logic [31:0] gold_rd(input logic [11:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : init_word(a);
  endfunction

  // Scoreboard: fetch is forced through once it has been refused STARVE times in a row.
  always @(negedge clk) begin : compare
    logic        eig, edg, ewe, eifv, edv;
    logic [31:0] eifd, edd;
    logic [11:0] eaddr;
    rd_t         e;
    cyc++;
    if (!rst) begin
      pend.delete();
      streak = 0;
`ifdef MEM_ARB_PERF_EN
      e_pif = 0; e_pd = 0; e_pcf = 0;
`endif
      for (int g = 0; g < 2; g++) begin
        check_output($sformatf("rst_outs[%0d]", g),
                     {25'd0, if_gnt[g], d_gnt[g], stallreq[g], mem_ce[g], mem_we[g], if_rvalid[g], d_rvalid[g]}, 32'd0);
        check_output($sformatf("rst_if_rdata[%0d]", g), if_rdata[g], 32'd0);
        check_output($sformatf("rst_d_rdata[%0d]", g), d_rdata[g], 32'd0);
        check_output($sformatf("rst_addr[%0d]", g), {20'd0, mem_addr[g]}, 32'd0);
`ifdef MEM_ARB_PERF_EN
        check_output($sformatf("rst_perf_if[%0d]", g), perf_if[g], 32'd0);
        check_output($sformatf("rst_perf_cf[%0d]", g), perf_cf[g], 32'd0);
`endif
      end
    end else begin
      eig = 1'b0;
      edg = 1'b0;
      if (if_req && d_req) begin
        if (streak >= STARVE) eig = 1'b1;
        else edg = 1'b1;
      end else if (if_req) eig = 1'b1;
      else if (d_req) edg = 1'b1;
      ewe   = edg && d_we && (d_sel != 4'd0);
      eaddr = eig ? if_addr : (edg ? d_addr : 12'd0);
      for (int g = 0; g < 2; g++) begin
        eifv = 1'b0; edv = 1'b0; eifd = 32'd0; edd = 32'd0;
        foreach (pend[k]) begin
          if (pend[k].due == cyc && pend[k].inst == g) begin
            if (pend[k].owner) begin edv = 1'b1; edd = pend[k].data; end
            else begin eifv = 1'b1; eifd = pend[k].data; end
          end
        end
        check_output($sformatf("if_gnt[%0d]", g), {31'd0, if_gnt[g]}, {31'd0, eig});
        check_output($sformatf("d_gnt[%0d]", g), {31'd0, d_gnt[g]}, {31'd0, edg});
        check_output($sformatf("stallreq[%0d]", g), {31'd0, stallreq[g]},
                     {31'd0, (if_req && !eig) || (d_req && !edg)});
        check_output($sformatf("mem_ce[%0d]", g), {31'd0, mem_ce[g]}, {31'd0, eig || edg});
        check_output($sformatf("mem_we[%0d]", g), {31'd0, mem_we[g]}, {31'd0, ewe});
        check_output($sformatf("mem_addr[%0d]", g), {20'd0, mem_addr[g]}, {20'd0, eaddr});
        if (ewe) begin
          check_output($sformatf("mem_sel[%0d]", g), {28'd0, mem_sel[g]}, {28'd0, d_sel});
          check_output($sformatf("mem_wdata[%0d]", g), mem_wdata[g], d_wdata);
        end
        check_output($sformatf("if_rvalid[%0d]", g), {31'd0, if_rvalid[g]}, {31'd0, eifv});
        check_output($sformatf("d_rvalid[%0d]", g), {31'd0, d_rvalid[g]}, {31'd0, edv});
        check_output($sformatf("if_rdata[%0d]", g), if_rdata[g], eifd);
        check_output($sformatf("d_rdata[%0d]", g), d_rdata[g], edd);
`ifdef MEM_ARB_PERF_EN
        check_output($sformatf("perf_if[%0d]", g), perf_if[g], e_pif);
        check_output($sformatf("perf_d[%0d]", g), perf_d[g], e_pd);
        check_output($sformatf("perf_cf[%0d]", g), perf_cf[g], e_pcf);
`endif
      end
      for (int k = pend.size() - 1; k >= 0; k--) if (pend[k].due <= cyc) pend.delete(k);
      if (eig || (edg && !d_we)) begin
        for (int g = 0; g < 2; g++) begin
          e.due   = cyc + lat_of(g);
          e.inst  = g;
          e.owner = edg;
          e.data  = gold_rd(eaddr);
          pend.push_back(e);
        end
      end
      if (ewe) gold[int'(d_addr)] = merge(gold_rd(d_addr), d_wdata, d_sel);
      if (if_req && !eig) streak++;
      else streak = 0;
`ifdef MEM_ARB_PERF_EN
      if (eig) e_pif++;
      if (edg) e_pd++;
      if (if_req && d_req) e_pcf++;
`endif
    end
  end

  task automatic apply_stimulus(input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
                                input logic [3:0] ds, input logic [11:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_sel = ds; d_addr = da; d_wdata = dd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 12'd0, 1'b0, 1'b0, 4'd0, 12'd0, 32'd0);
  endtask

  initial begin : stimulus
    logic [8:0] rv_if_seq, rv_d_seq;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;

    apply_stimulus(1'b1, 12'h010, 1'b1, 1'b0, 4'h0, 12'h011, 32'd0);
    #2;
    check_output("rst_gnt_masked", {30'd0, if_gnt[0], d_gnt[0]}, 32'd0);
    check_output("rst_stall_masked", {31'd0, stallreq[0]}, 32'd0);
    idle(2);
    @(posedge clk); #1; rst = 1'b1;

    $display("[TB] fetch only");
    apply_stimulus(1'b1, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'd0);
    #2;
    check_output("t1_if_gnt", {31'd0, if_gnt[0]}, 32'd1);
    check_output("t1_stall", {31'd0, stallreq[0]}, 32'd0);
    check_output("t1_mem_addr", {20'd0, mem_addr[0]}, 32'h010);
    idle(1);
    #2;
    check_output("t1_if_rvalid", {31'd0, if_rvalid[0]}, 32'd1);
    check_output("t1_if_rdata", if_rdata[0], 32'hC0DE0010);
    idle(4);

    $display("[TB] conflict starvation");
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, 12'h030, 1'b1, 1'b0, 4'h0, 12'h040, 32'd0);
      #2;
      check_output($sformatf("t2_grant%0d", k), {30'd0, if_gnt[0], d_gnt[0]}, (k == 4) ? 32'd2 : 32'd1);
      check_output($sformatf("t2_stall%0d", k), {31'd0, stallreq[0]}, 32'd1);
    end
    idle(4);

    $display("[TB] store then load");
    apply_stimulus(1'b0, 12'd0, 1'b1, 1'b1, 4'hF, 12'h020, 32'hDEADBEEF);
    #2;
    check_output("t3_store_we", {31'd0, mem_we[0]}, 32'd1);
    apply_stimulus(1'b0, 12'd0, 1'b1, 1'b0, 4'h0, 12'h020, 32'd0);
    #2;
    check_output("t3_store_no_rvalid", {31'd0, d_rvalid[0]}, 32'd0);
    idle(1);
    #2;
    check_output("t3_d_rvalid", {31'd0, d_rvalid[0]}, 32'd1);
    check_output("t3_d_rdata", d_rdata[0], 32'hDEADBEEF);
    idle(4);

    $display("[TB] partial and empty stores");
    apply_stimulus(1'b0, 12'd0, 1'b1, 1'b1, 4'hF, 12'h050, 32'hFFFFFFFF);
    apply_stimulus(1'b0, 12'd0, 1'b1, 1'b1, 4'b0011, 12'h050, 32'h0000ABCD);
    apply_stimulus(1'b0, 12'd0, 1'b1, 1'b1, 4'b0000, 12'h050, 32'h12345678);
    #2;
    check_output("t4_nop_ce", {31'd0, mem_ce[0]}, 32'd1);
    check_output("t4_nop_we", {31'd0, mem_we[0]}, 32'd0);
    apply_stimulus(1'b0, 12'd0, 1'b1, 1'b0, 4'h0, 12'h050, 32'd0);
    #2;
    check_output("t4_nop_no_rvalid", {31'd0, d_rvalid[0]}, 32'd0);
    idle(1);
    #2;
    check_output("t4_d_rdata", d_rdata[0], 32'hFFFFABCD);
    idle(4);

    $display("[TB] alternating reads, RD_LAT=3");
    rv_if_seq = '0;
    rv_d_seq  = '0;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) apply_stimulus(k % 2 == 0, 12'h100 + 12'(k), k % 2 == 1, 1'b0, 4'h0, 12'h200 + 12'(k), 32'd0);
      else idle(1);
      #2;
      rv_if_seq[k] = if_rvalid[1];
      rv_d_seq[k]  = d_rvalid[1];
      if (k == 3) check_output("t5_if_rdata", if_rdata[1], 32'hC0DE0100);
      if (k == 4) check_output("t5_d_rdata", d_rdata[1], 32'hC0DE0201);
    end
    check_output("t5_if_rvalid_seq", {23'd0, rv_if_seq}, 32'h0A8);
    check_output("t5_d_rvalid_seq", {23'd0, rv_d_seq}, 32'h150);
    idle(4);

    $display("[TB] reset mid-read");
    apply_stimulus(1'b1, 12'h060, 1'b0, 1'b0, 4'h0, 12'h000, 32'd0);
    #2;
    check_output("t6_if_gnt", {31'd0, if_gnt[1]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    if_req = 1'b0;
    #2;
    check_output("t6_rvalid_dropped", {30'd0, if_rvalid[0], if_rvalid[1]}, 32'd0);
`ifdef MEM_ARB_PERF_EN
    check_output("t6_perf_zero", perf_d[1], 32'd0);
`endif
    idle(2);
    @(posedge clk); #1; rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      #2;
      check_output($sformatf("t6_no_rvalid%0d", k), {30'd0, if_rvalid[0], if_rvalid[1]}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
